// File: rtl/pol_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : pol_rd_sched
// Brief    : Round-robin GLB read scheduler for POOL_CORE pooling cores, with
//            in-order return steering and flush/drain handshake.
//            Optional POL_SCH_PERF_EN adds grant/stall counters on SCHCCU_Perf.
// Revision : 1.0 - initial release
// ============================================================================
module pol_rd_sched #(
    parameter int POOL_CORE      = 6,
    parameter int POOL_COMP_CORE = 64,
    parameter int IDX_WIDTH      = 10,
    parameter int ACT_WIDTH      = 8,
    parameter int OUT_AW         = 2
) (
    input  logic                                clk,
    input  logic                                Reset,
    input  logic [POOL_CORE-1:0]                POLSCH_AddrVld,
    input  logic [IDX_WIDTH*POOL_CORE-1:0]      POLSCH_Addr,
    output logic [POOL_CORE-1:0]                SCHPOL_AddrRdy,
    output logic                                SCHGLB_AddrVld,
    output logic [IDX_WIDTH-1:0]                SCHGLB_Addr,
    input  logic                                GLBSCH_AddrRdy,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBSCH_Ofm,
    input  logic                                GLBSCH_OfmVld,
    output logic                                SCHGLB_OfmRdy,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] SCHPOL_Ofm,
    output logic [POOL_CORE-1:0]                SCHPOL_OfmVld,
    input  logic [POOL_CORE-1:0]                POLSCH_OfmRdy,
    input  logic                                CCUSCH_Flush,
    output logic                                SCHCCU_FlushDone
`ifdef POL_SCH_PERF_EN
   ,output logic [16*(POOL_CORE+1)-1:0]         SCHCCU_Perf
`endif
);

    localparam int                  c_PTR_W    = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;
    localparam int                  c_DEPTH    = 1 << OUT_AW;
    localparam logic [OUT_AW:0]     c_CNT_FULL = (OUT_AW+1)'(c_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_LAST     = c_PTR_W'(POOL_CORE-1);
    localparam logic [POOL_CORE-1:0] c_OH0     = POOL_CORE'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_run;

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic                   r_out_vld;
    logic [IDX_WIDTH-1:0]   r_out_addr;
    logic [OUT_AW:0]        r_cnt;
    logic [OUT_AW-1:0]      r_wr_ptr;
    logic [OUT_AW-1:0]      r_rd_ptr;
    logic [c_PTR_W-1:0]     r_tag_mem [c_DEPTH];

    logic                   w_stage_pop;
    logic                   w_stage_free;
    logic                   w_not_full;
    logic                   w_grant_en;
    logic                   w_gnt_found;
    logic [c_PTR_W-1:0]     w_gnt_idx;
    logic [c_PTR_W-1:0]     w_cand;
    logic                   w_accept;
    logic [IDX_WIDTH-1:0]   w_gnt_addr;
    logic                   w_q_nonempty;
    logic [c_PTR_W-1:0]     w_head;
    logic                   w_ret_pop;

    assign w_stage_pop  = r_out_vld & GLBSCH_AddrRdy;
    assign w_stage_free = ~r_out_vld | GLBSCH_AddrRdy;
    assign w_not_full   = (r_cnt != c_CNT_FULL);
    assign w_grant_en   = w_run & w_stage_free & w_not_full;

    // Search upward from the pointer; first requesting core wins
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < POOL_CORE; k++) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + k) % POOL_CORE);
            if (!w_gnt_found && POLSCH_AddrVld[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_accept       = w_grant_en & w_gnt_found;
    assign SCHPOL_AddrRdy = w_accept ? (c_OH0 << w_gnt_idx) : '0;
    assign w_gnt_addr     = POLSCH_Addr[IDX_WIDTH*w_gnt_idx +: IDX_WIDTH];

    assign SCHGLB_AddrVld = r_out_vld;
    assign SCHGLB_Addr    = r_out_addr;

    // Return path: head tag selects the destination core, data is broadcast
    assign w_q_nonempty   = (r_cnt != '0);
    assign w_head         = r_tag_mem[r_rd_ptr];
    assign SCHPOL_OfmVld  = (GLBSCH_OfmVld & w_q_nonempty) ? (c_OH0 << w_head) : '0;
    assign SCHGLB_OfmRdy  = w_q_nonempty & POLSCH_OfmRdy[w_head];
    assign SCHPOL_Ofm     = GLBSCH_Ofm;
    assign w_ret_pop      = GLBSCH_OfmVld & SCHGLB_OfmRdy;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_rr_ptr   <= '0;
            r_out_vld  <= 1'b0;
            r_out_addr <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr   <= (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;
                r_out_vld  <= 1'b1;
                r_out_addr <= w_gnt_addr;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end else if (w_stage_pop) begin
                r_out_vld  <= 1'b0;
            end
            if (w_ret_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_ret_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr] <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD keeps grants off after the done pulse until flush is released
    always_comb begin
        w_state_nxt      = r_state;
        w_run            = 1'b0;
        SCHCCU_FlushDone = 1'b0;
        case (r_state)
            S_RUN: begin
                w_run = 1'b1;
                if (CCUSCH_Flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_cnt == '0) && !r_out_vld) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                SCHCCU_FlushDone = 1'b1;
                w_state_nxt      = CCUSCH_Flush ? S_HOLD : S_RUN;
            end
            S_HOLD: begin
                if (!CCUSCH_Flush) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

`ifdef POL_SCH_PERF_EN
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    assign w_stall = (|POLSCH_AddrVld) & w_run & ~w_not_full;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign SCHCCU_Perf[16*POOL_CORE +: 16] = r_stall_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < POOL_CORE; gi++) begin : g_perf_core
            logic [15:0] r_gnt_cnt;
            always_ff @(posedge clk) begin
                if (Reset) begin
                    r_gnt_cnt <= '0;
                end else if (SCHPOL_AddrRdy[gi] && POLSCH_AddrVld[gi] && (r_gnt_cnt != 16'hFFFF)) begin
                    r_gnt_cnt <= r_gnt_cnt + 16'd1;
                end
            end
            assign SCHCCU_Perf[16*gi +: 16] = r_gnt_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_pol_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pol_rd_sched
// Brief    : Directed self-checking bench for pol_rd_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pol_rd_sched;

    localparam int NC = 6;
    localparam int CC = 64;
    localparam int IW = 10;
    localparam int AW = 8;
    localparam int OA = 2;

    logic                 clk = 1'b0;
    logic                 Reset;
    logic [NC-1:0]        POLSCH_AddrVld;
    logic [IW*NC-1:0]     POLSCH_Addr;
    logic [NC-1:0]        SCHPOL_AddrRdy;
    logic                 SCHGLB_AddrVld;
    logic [IW-1:0]        SCHGLB_Addr;
    logic                 GLBSCH_AddrRdy;
    logic [AW*CC-1:0]     GLBSCH_Ofm;
    logic                 GLBSCH_OfmVld;
    logic                 SCHGLB_OfmRdy;
    logic [AW*CC-1:0]     SCHPOL_Ofm;
    logic [NC-1:0]        SCHPOL_OfmVld;
    logic [NC-1:0]        POLSCH_OfmRdy;
    logic                 CCUSCH_Flush;
    logic                 SCHCCU_FlushDone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pol_rd_sched #(
        .POOL_CORE      (NC),
        .POOL_COMP_CORE (CC),
        .IDX_WIDTH      (IW),
        .ACT_WIDTH      (AW),
        .OUT_AW         (OA)
    ) u_dut (
        .clk              (clk),
        .Reset            (Reset),
        .POLSCH_AddrVld   (POLSCH_AddrVld),
        .POLSCH_Addr      (POLSCH_Addr),
        .SCHPOL_AddrRdy   (SCHPOL_AddrRdy),
        .SCHGLB_AddrVld   (SCHGLB_AddrVld),
        .SCHGLB_Addr      (SCHGLB_Addr),
        .GLBSCH_AddrRdy   (GLBSCH_AddrRdy),
        .GLBSCH_Ofm       (GLBSCH_Ofm),
        .GLBSCH_OfmVld    (GLBSCH_OfmVld),
        .SCHGLB_OfmRdy    (SCHGLB_OfmRdy),
        .SCHPOL_Ofm       (SCHPOL_Ofm),
        .SCHPOL_OfmVld    (SCHPOL_OfmVld),
        .POLSCH_OfmRdy    (POLSCH_OfmRdy),
        .CCUSCH_Flush     (CCUSCH_Flush),
        .SCHCCU_FlushDone (SCHCCU_FlushDone)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NC; i++) begin
            POLSCH_Addr[IW*i +: IW] = IW'(16 + i);
        end
    endtask

    task automatic idle_inputs();
        POLSCH_AddrVld = '0;
        GLBSCH_AddrRdy = 1'b0;
        GLBSCH_Ofm     = '0;
        GLBSCH_OfmVld  = 1'b0;
        POLSCH_OfmRdy  = '0;
        CCUSCH_Flush   = 1'b0;
        set_addrs();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle_inputs();
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr_rdy"}, 64'(SCHPOL_AddrRdy), 64'h0);
        chk({tag, "_glb_vld"},  64'(SCHGLB_AddrVld), 64'h0);
        chk({tag, "_glb_addr"}, 64'(SCHGLB_Addr), 64'h0);
        chk({tag, "_ofm_rdy"},  64'(SCHGLB_OfmRdy), 64'h0);
        chk({tag, "_ofm_vld"},  64'(SCHPOL_OfmVld), 64'h0);
        chk({tag, "_done"},     64'(SCHCCU_FlushDone), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // ---------------- reset state
        do_reset();
        Reset = 1'b1;
        step();
        settle();
        chk_all_zero("rst");
        Reset = 1'b0;

        // ---------------- round-robin at full rate with returns every cycle
        do_reset();
        POLSCH_AddrVld = '1;
        GLBSCH_AddrRdy = 1'b1;
        POLSCH_OfmRdy  = '1;
        GLBSCH_OfmVld  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            GLBSCH_Ofm = {CC{8'(c + 1)}};
            settle();
            chk("rr_grant", 64'(SCHPOL_AddrRdy), 64'(1) << (c % NC));
            if (c == 0) begin
                chk("rr_ofm_vld_empty", 64'(SCHPOL_OfmVld), 64'h0);
                chk("rr_glb_vld0", 64'(SCHGLB_AddrVld), 64'h0);
            end else begin
                chk("rr_glb_vld",  64'(SCHGLB_AddrVld), 64'h1);
                chk("rr_glb_addr", 64'(SCHGLB_Addr), 64'(16 + ((c - 1) % NC)));
                chk("rr_ofm_vld",  64'(SCHPOL_OfmVld), 64'(1) << ((c - 1) % NC));
            end
            if (c == 3) begin
                chk("rr_ofm_data", SCHPOL_Ofm[63:0], 64'h0404040404040404);
            end
            step();
        end

        // ---------------- queue full: four accepts then stall
        do_reset();
        POLSCH_AddrVld = '1;
        GLBSCH_AddrRdy = 1'b1;
        POLSCH_OfmRdy  = '1;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("full_grant", 64'(SCHPOL_AddrRdy), (c < 4) ? (64'(1) << c) : 64'h0);
            step();
        end
        GLBSCH_OfmVld = 1'b1;
        settle();
        chk("full_ret_vld",  64'(SCHPOL_OfmVld), 64'h01);
        chk("full_ret_rdy",  64'(SCHGLB_OfmRdy), 64'h1);
        chk("full_same_cyc", 64'(SCHPOL_AddrRdy), 64'h0);
        step();
        GLBSCH_OfmVld = 1'b0;
        settle();
        chk("full_reaccept", 64'(SCHPOL_AddrRdy), 64'h10);
        step();

        // ---------------- return backpressure from core 3
        do_reset();
        POLSCH_AddrVld = 6'b001000;
        GLBSCH_AddrRdy = 1'b1;
        settle();
        chk("bp_grant3", 64'(SCHPOL_AddrRdy), 64'h08);
        step();
        POLSCH_AddrVld = '0;
        GLBSCH_OfmVld  = 1'b1;
        GLBSCH_Ofm     = {CC{8'h3C}};
        POLSCH_OfmRdy  = 6'b110111;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_rdy_low", 64'(SCHGLB_OfmRdy), 64'h0);
            chk("bp_vld_held", 64'(SCHPOL_OfmVld), 64'h08);
            step();
        end
        POLSCH_OfmRdy = '1;
        settle();
        chk("bp_rdy_high", 64'(SCHGLB_OfmRdy), 64'h1);
        chk("bp_vld_dlv",  64'(SCHPOL_OfmVld), 64'h08);
        chk("bp_ofm_top",  SCHPOL_Ofm[AW*CC-1 -: 64], 64'h3C3C3C3C3C3C3C3C);
        step();
        settle();
        chk("bp_stray_rdy", 64'(SCHGLB_OfmRdy), 64'h0);
        chk("bp_stray_vld", 64'(SCHPOL_OfmVld), 64'h0);
        GLBSCH_OfmVld = 1'b0;

        // ---------------- GLB address backpressure, then reset mid-flight
        do_reset();
        POLSCH_Addr[IW*2 +: IW] = 10'h2A;
        POLSCH_AddrVld = 6'b000100;
        settle();
        chk("ab_grant2", 64'(SCHPOL_AddrRdy), 64'h04);
        step();
        POLSCH_AddrVld = 6'b100100;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ab_addr_hold", 64'(SCHGLB_Addr), 64'h2A);
            chk("ab_vld_hold",  64'(SCHGLB_AddrVld), 64'h1);
            chk("ab_no_grant",  64'(SCHPOL_AddrRdy), 64'h0);
            step();
        end
        GLBSCH_AddrRdy = 1'b1;
        settle();
        chk("ab_addr_pop",  64'(SCHGLB_Addr), 64'h2A);
        chk("ab_grant5",    64'(SCHPOL_AddrRdy), 64'h20);
        step();
        POLSCH_AddrVld = '0;
        settle();
        chk("ab_next_addr", 64'(SCHGLB_Addr), 64'h15);
        chk("ab_next_vld",  64'(SCHGLB_AddrVld), 64'h1);
        step();
        Reset = 1'b1;
        step();
        settle();
        chk_all_zero("midrst");
        Reset = 1'b0;
        GLBSCH_OfmVld  = 1'b1;
        POLSCH_OfmRdy  = '1;
        POLSCH_AddrVld = '1;
        settle();
        chk("midrst_stray_rdy", 64'(SCHGLB_OfmRdy), 64'h0);
        chk("midrst_stray_vld", 64'(SCHPOL_OfmVld), 64'h0);
        chk("midrst_ptr0",      64'(SCHPOL_AddrRdy), 64'h01);
        step();
        GLBSCH_OfmVld  = 1'b0;
        POLSCH_AddrVld = '0;

        // ---------------- flush with three outstanding
        do_reset();
        POLSCH_AddrVld = '1;
        GLBSCH_AddrRdy = 1'b1;
        POLSCH_OfmRdy  = '1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("fl_grant", 64'(SCHPOL_AddrRdy), 64'(1) << c);
            step();
        end
        POLSCH_AddrVld = '0;
        CCUSCH_Flush   = 1'b1;
        step();
        POLSCH_AddrVld = '1;
        settle();
        chk("fl_no_grant", 64'(SCHPOL_AddrRdy), 64'h0);
        chk("fl_no_done",  64'(SCHCCU_FlushDone), 64'h0);
        step();
        GLBSCH_OfmVld = 1'b1;
        for (int r = 0; r < 3; r++) begin
            settle();
            chk("fl_ret_vld",   64'(SCHPOL_OfmVld), 64'(1) << r);
            chk("fl_ret_nogr",  64'(SCHPOL_AddrRdy), 64'h0);
            chk("fl_ret_ndone", 64'(SCHCCU_FlushDone), 64'h0);
            step();
        end
        GLBSCH_OfmVld = 1'b0;
        w = 0;
        settle();
        while (!SCHCCU_FlushDone && w < 5) begin
            step();
            settle();
            w++;
        end
        chk("fl_done_pulse", 64'(SCHCCU_FlushDone), 64'h1);
        step();
        settle();
        chk("fl_done_1cyc", 64'(SCHCCU_FlushDone), 64'h0);
        chk("fl_hold_nogr", 64'(SCHPOL_AddrRdy), 64'h0);
        step();
        settle();
        chk("fl_hold_ndone", 64'(SCHCCU_FlushDone), 64'h0);
        chk("fl_hold_nogr2", 64'(SCHPOL_AddrRdy), 64'h0);
        CCUSCH_Flush = 1'b0;
        step();
        settle();
        chk("fl_resume", 64'(SCHPOL_AddrRdy), 64'h08);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
